sram_arbiter: RTL



---
 rtl/sram_arbiter_if.sv | 14 +
 rtl/sram_arbiter.sv | 76 +++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side handshake bundle for ports A and B
interface sram_arbiter_if;
  logic a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [14:0] a_addr, b_addr;
  logic [7:0] a_wdata, a_rdata, b_wdata, b_rdata;
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_ack, a_rdata, b_ack, b_rdata
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_ack, a_rdata, b_ack, b_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port controller for a 32 KiB async SRAM
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  sram_arbiter_if.slave bus,
  output logic [14:0]  sram_addr,
  inout  wire  [7:0]   sram_data,
  output logic         sram_ce_n,
  output logic         sram_oe_n,
  output logic         sram_we_n
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic       last_grant, cur, l_we, drive, grant_b;
  logic [7:0] l_wdata;
  logic [3:0] cnt;
  // B wins when alone, or on a tie when A was served last
  always_comb grant_b = bus.b_req & (~bus.a_req | ~last_grant);
  assign sram_data = drive ? l_wdata : 8'bz;
  // Transaction sequencer; every pin-facing signal comes straight from a flop
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur         <= 1'b0;
      l_we        <= 1'b0;
      drive       <= 1'b0;
      l_wdata     <= '0;
      cnt         <= '0;
      sram_addr   <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (bus.a_req | bus.b_req) begin
          state      <= SETUP;
          cur        <= grant_b;
          last_grant <= grant_b;
          l_we       <= grant_b ? bus.b_we : bus.a_we;
          drive      <= grant_b ? bus.b_we : bus.a_we;
          sram_addr  <= grant_b ? bus.b_addr : bus.a_addr;
          l_wdata    <= grant_b ? bus.b_wdata : bus.a_wdata;
          sram_ce_n  <= 1'b0;
        end
        SETUP: begin
          state     <= ACCESS;
          cnt       <= 4'(ACCESS_CYCLES - 1);
          sram_oe_n <= l_we;
          sram_we_n <= ~l_we;
        end
        ACCESS: if (cnt == 4'd0) begin
          state     <= HOLD;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          bus.a_ack <= ~cur;
          bus.b_ack <= cur;
          if (!l_we && !cur) bus.a_rdata <= sram_data;
          if (!l_we && cur) bus.b_rdata <= sram_data;
        end else cnt <= cnt - 4'd1;
        default: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          drive     <= 1'b0;
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
        end
      endcase
    end
endmodule
